// File: rtl/riscv_pkg.sv
// Shared RV64 front-end types: opcodes, fetch FSM states and fault causes.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        HALT  = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_IMEM_ERR = 2'b01,
        CAUSE_MISALIGN = 2'b10
    } fault_cause_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC generation: sequential or branch target, plus word-alignment check.
module fetch_pc_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_imm_i,
    output logic [XLEN-1:0] target_c_o,
    output logic            misaligned_c_o
);

    // Immediate is in halfword units; all sums wrap modulo 2^64.
    always_comb begin
        target_c_o     = br_taken_i ? (pc_i + (br_imm_i << 1)) : (pc_i + XLEN'(4));
        misaligned_c_o = (target_c_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from imem, hands words to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    input  logic        br_taken_i,
    input  logic [63:0] br_imm_i,
    output logic        halt_o,
    output logic [1:0]  fault_cause_o,
    output logic [63:0] inst_cnt_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    fault_cause_t    cause_q, cause_d;
    logic            halt_q, halt_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] target;
    logic            misaligned;

    fetch_pc_gen u_pc_gen (
        .pc_i           (pc_q),
        .br_taken_i     (br_taken_i),
        .br_imm_i       (br_imm_i),
        .target_c_o     (target),
        .misaligned_c_o (misaligned)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
            halt_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            halt_q  <= halt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; req/valid are registered decodes of the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        halt_d  = halt_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_rvalid_i) begin
                    if (imem_err_i) begin
                        cause_d = CAUSE_IMEM_ERR;
                        halt_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        inst_d  = imem_rdata_i;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (inst_ready_i) begin
                    cnt_d = cnt_q + XLEN'(1);
                    if (misaligned) begin
                        cause_d = CAUSE_MISALIGN;
                        halt_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
        req_d   = (state_d == FETCH);
        valid_d = (state_d == HOLD);
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign inst_valid_o  = valid_q;
    assign inst_o        = inst_q;
    assign pc_o          = pc_q;
    assign halt_o        = halt_q;
    assign fault_cause_o = 2'(cause_q);
    assign inst_cnt_o    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        br_taken_i;
    logic [63:0] br_imm_i;
    logic        halt_o;
    logic [1:0]  fault_cause_o;
    logic [63:0] inst_cnt_o;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .br_taken_i    (br_taken_i),
        .br_imm_i      (br_imm_i),
        .halt_o        (halt_o),
        .fault_cause_o (fault_cause_o),
        .inst_cnt_o    (inst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Model of what the fetch stage should be showing after the next edge.
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_cnt;
    logic        m_halt;
    logic [1:0]  m_cause;
    logic        m_idle, m_fetching, m_holding;
    int          m_wait;

    // Stimulus knobs.
    logic        g_rst    = 1'b1;
    int          g_lat    = -1;    // -1 random 0..3 extra wait cycles
    int          g_err    = 2;     // 0 random 3%, 1 always, 2 never
    int          g_ready  = 1;     // 0 random, 1 always, 2 never
    logic        g_fixed  = 1'b0;
    logic        g_spur   = 1'b0;
    logic        g_force  = 1'b0;
    logic        g_tk     = 1'b0;
    logic [63:0] g_imm    = '0;
    logic        g_acc    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc       = 64'h0;
        m_inst     = 32'h0;
        m_cnt      = 64'h0;
        m_halt     = 1'b0;
        m_cause    = 2'b00;
        m_idle     = 1'b1;
        m_fetching = 1'b0;
        m_holding  = 1'b0;
        m_wait     = 0;
    endfunction

    function automatic void new_fetch();
        m_fetching = 1'b1;
        m_wait     = (g_lat < 0) ? int'($urandom_range(0, 3)) : g_lat;
    endfunction

    // One cycle: compare at the falling edge, then drive inputs for the next rising edge.
    task automatic step();
        logic        rdy;
        logic        tk;
        logic [63:0] imm;
        logic [63:0] tgt;
        int          v;
        @(negedge clk_i);
        chk("inst_cnt", inst_cnt_o, m_cnt);
        chk("halt", 64'(halt_o), 64'(m_halt));
        chk("cause", 64'(fault_cause_o), 64'(m_cause));
        chk("req", 64'(imem_req_o), 64'(m_fetching && !m_idle && m_wait >= 0 && !m_holding
                                        && !m_halt && rst_ni ? 1'b1 : 1'b0) & 64'(m_fetching));
        if (imem_req_o) chk("imem_addr", imem_addr_o, m_pc);
        chk("inst_valid", 64'(inst_valid_o), 64'(m_holding));
        chk("pc", pc_o, m_pc);
        chk("inst", 64'(inst_o), 64'(m_inst));

        rst_ni        = 1'b1;
        imem_rvalid_i = 1'($urandom_range(0, 1));
        imem_err_i    = 1'($urandom_range(0, 1));
        imem_rdata_i  = $urandom;
        inst_ready_i  = 1'($urandom_range(0, 1));
        br_taken_i    = 1'($urandom_range(0, 1));
        br_imm_i      = {$urandom, $urandom};

        if (g_rst) begin
            rst_ni = 1'b0;
            model_reset();
        end else if (m_idle) begin
            imem_rvalid_i = g_spur | imem_rvalid_i;
            m_idle = 1'b0;
            new_fetch();
        end else if (m_fetching) begin
            if (m_wait > 0) begin
                imem_rvalid_i = 1'b0;
                m_wait--;
            end else begin
                imem_rvalid_i = 1'b1;
                imem_err_i    = (g_err == 1) ? 1'b1 :
                                (g_err == 0) ? ($urandom_range(0, 99) < 3) : 1'b0;
                if (g_fixed) imem_rdata_i = 32'h00500093;
                m_fetching = 1'b0;
                if (imem_err_i) begin
                    m_halt  = 1'b1;
                    m_cause = 2'b01;
                end else begin
                    m_inst    = imem_rdata_i;
                    m_holding = 1'b1;
                end
            end
        end else if (m_holding) begin
            rdy = (g_ready == 1) ? 1'b1 : (g_ready == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            inst_ready_i = rdy;
            if (rdy) begin
                if (g_force) begin
                    tk  = g_tk;
                    imm = g_imm;
                end else begin
                    tk = 1'($urandom_range(0, 1));
                    v  = int'($urandom_range(0, 128)) - 64;
                    v  = ($urandom_range(0, 7) == 0) ? (v | 1) : (v & ~1);
                    imm = 64'(v);
                end
                br_taken_i = tk;
                br_imm_i   = imm;
                g_acc      = 1'b1;
                m_cnt      = m_cnt + 64'd1;
                tgt        = tk ? (m_pc + imm * 64'd2) : (m_pc + 64'd4);
                m_holding  = 1'b0;
                if (tgt % 64'd4 != 64'd0) begin
                    m_halt  = 1'b1;
                    m_cause = 2'b10;
                end else begin
                    m_pc = tgt;
                    new_fetch();
                end
            end
        end
    endtask

    task automatic do_accept(input logic tk, input logic [63:0] imm);
        g_force = 1'b1;
        g_tk    = tk;
        g_imm   = imm;
        g_acc   = 1'b0;
        for (int i = 0; i < 20 && !g_acc; i++) step();
        chk("accept_seen", 64'(g_acc), 64'd1);
        g_force = 1'b0;
    endtask

    task automatic do_reset();
        g_rst = 1'b1;
        step();
        step();
        g_rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        rst_ni = 1'b0; imem_rvalid_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = '0;
        inst_ready_i = 1'b0; br_taken_i = 1'b0; br_imm_i = '0;

        // Sequential fetch with 1-cycle memory.
        g_lat = 0; g_ready = 1; g_fixed = 1'b1;
        g_rst = 1'b1;
        step();
        step();
        chk("rst_req", 64'(imem_req_o), 64'd0);
        chk("rst_cnt", inst_cnt_o, 64'd0);
        g_rst = 1'b0;
        step();
        step();
        chk("first_req", 64'(imem_req_o), 64'd1);
        chk("first_addr", imem_addr_o, 64'h0);
        do_accept(1'b0, '0);
        do_accept(1'b0, '0);
        do_accept(1'b0, '0);
        step();
        chk("seq_cnt", inst_cnt_o, 64'd3);
        chk("seq_addr", imem_addr_o, 64'hC);
        chk("seq_inst", 64'(inst_o), 64'h00500093);

        // Forward and backward branches.
        do_accept(1'b0, '0);
        do_accept(1'b1, 64'h8);
        step();
        chk("br_fwd", imem_addr_o, 64'h20);
        do_accept(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        do_accept(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        chk("br_back", imem_addr_o, 64'h0);

        // Backpressure in HOLD.
        g_ready = 2;
        for (int i = 0; i < 7; i++) step();
        chk("bp_valid", 64'(inst_valid_o), 64'd1);
        chk("bp_req", 64'(imem_req_o), 64'd0);
        chk("bp_cnt", inst_cnt_o, 64'd7);
        g_ready = 1;

        // Slow memory then bus error.
        g_lat = 3; g_err = 1;
        do_accept(1'b0, '0);
        for (int i = 0; i < 8; i++) step();
        chk("err_halt", 64'(halt_o), 64'd1);
        chk("err_cause", 64'(fault_cause_o), 64'd1);
        chk("err_req", 64'(imem_req_o), 64'd0);
        g_lat = 0; g_err = 2;

        // Misaligned branch target.
        do_reset();
        do_accept(1'b1, 64'h20);
        do_accept(1'b1, 64'h1);
        step();
        chk("mis_halt", 64'(halt_o), 64'd1);
        chk("mis_cause", 64'(fault_cause_o), 64'd2);
        chk("mis_pc", pc_o, 64'h40);
        chk("mis_cnt", inst_cnt_o, 64'd2);

        // Reset during FETCH with late rvalid.
        do_reset();
        do_accept(1'b0, '0);
        g_lat = 1;
        do_accept(1'b0, '0);
        step();
        chk("mid_req", 64'(imem_req_o), 64'd1);
        g_rst = 1'b1;
        step();
        g_rst = 1'b0; g_spur = 1'b1;
        step();
        g_spur = 1'b0;
        chk("mid_pc", pc_o, 64'h0);
        chk("mid_valid", 64'(inst_valid_o), 64'd0);
        g_lat = 0;
        step();
        do_accept(1'b0, '0);
        step();
        chk("mid_resume", imem_addr_o, 64'h4);

        // Random episodes.
        g_fixed = 1'b0; g_lat = -1; g_err = 0; g_ready = 0;
        for (int e = 0; e < 30; e++) begin
            do_reset();
            for (int i = 0; i < 60; i++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
